acq_capture_ctrl: RTL and testbench
===================================

Name: acq_capture_ctrl

Overview:
- Downstream of the edge trigger. Consumes its registered trigger output and the same 14-bit ADC stream.
- Drives the write port of an external dual-port sample RAM used as a circular buffer, giving a pre-trigger/post-trigger capture window.
- Reports the RAM address of the trigger sample, so readout logic can unroll the ring starting at (trig_addr - preTrig).

Parameters:
- ADDR_W, 12, sample RAM address width; buffer depth = 2^ADDR_W.
- DATA_W, 14, ADC sample width.

Ports:
- clkIn  in  1  sample clock, shared with the ADC and the trigger.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse; starts a capture from IDLE or DONE.
- abort  in  1  single-cycle pulse; returns to IDLE from any state.
- autoRearm  in  1  when 1, DONE re-arms automatically after one cycle.
- preTrig  in  ADDR_W  number of samples kept before the trigger sample.
- postTrig  in  ADDR_W  number of samples kept after the trigger sample.
- trigIn  in  1  trigger level from the edge-trigger stage (q).
- adc_data  in  DATA_W  raw ADC sample.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- trig_addr  out  ADDR_W  RAM address holding the trigger sample.
- busy  out  1  high in PRETRIG, ARMED and POSTTRIG.
- done  out  1  high while in DONE.
- trigd  out  1  one-cycle pulse when the trigger is accepted.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, trig_addr=0, busy=0, done=0, trigd=0; trigger history register=0; counters=0.
- Data path: wr_data is adc_data registered once. wr_en and wr_addr are registered in the same edge, so the RAM sees an aligned triple.
- Address: wr_addr increments by 1 on every cycle with wr_en=1 and wraps from 2^ADDR_W-1 to 0 (natural modulo).
- Trigger edge: trig_prev is trigIn registered. Accept = trigIn & ~trig_prev, and only in ARMED. A trigger level that is already high on entry to ARMED is not accepted until it falls and rises again.
- preTrig and postTrig are latched on arm. Changes during a capture are ignored.
- Clamp: if preTrig + postTrig + 1 > 2^ADDR_W, postTrig_eff = 2^ADDR_W - 1 - preTrig.
- States:
  - IDLE: wr_en=0. On arm, go to PRETRIG, zero the fill counter, keep wr_addr.
  - PRETRIG: wr_en=1; fill counter counts writes. When count reaches preTrig, go to ARMED. If preTrig=0, arm goes directly to ARMED.
  - ARMED: wr_en=1; keeps overwriting the ring. On accept: trig_addr = address written that cycle, trigd=1 for 1 cycle, post counter=0, go to POSTTRIG. Edges during PRETRIG are ignored.
  - POSTTRIG: wr_en=1 for exactly postTrig_eff further writes, then go to DONE. If postTrig_eff=0, the accept cycle goes straight to DONE, so only the trigger sample is written.
  - DONE: wr_en=0, done=1, wr_addr frozen.
    - arm → PRETRIG.
    - autoRearm=1 → PRETRIG after exactly one cycle in DONE.
- Simultaneous events:
  - abort beats arm, which beats accept.
  - arm while busy is ignored.
  - abort mid-capture: next cycle wr_en=0, state IDLE; trig_addr is kept; done stays 0.
- Total writes per capture = preTrig + 1 + postTrig_eff (minimum, when the trigger arrives immediately after ARMED).

Decomposition:
- Shared package acq_pkg holds:
  - the state enum (IDLE=0, PRETRIG=1, ARMED=2, POSTTRIG=3, DONE=4), so readout and status registers decode it identically;
  - default ADDR_W/DATA_W constants.
- One natural sub-module: acq_ring_addr, the wrapping write-address counter with enable, which the readout side can reuse.

Test Plan:
- Reset mid-POSTTRIG (rst asserted asynchronously) → all outputs are 0 in the same cycle, without waiting for a clock edge; IDLE after release.
- ADDR_W=4, preTrig=3, postTrig=4, arm, trigIn rising 10 cycles later → trigd pulse; trig_addr equals the address written that cycle; exactly 4 further writes; done=1; wr_addr frozen.
- preTrig=0, postTrig=0, trigIn high before arm → no accept while trigIn stays high. After trigIn falls and rises: a single write, then DONE.
- ADDR_W=4, preTrig=10, postTrig=10 → clamped to 5 post writes. Addresses wrap 15→0 correctly.
- Rising trigIn during PRETRIG (count 1 of 3) → ignored; the capture only triggers on a later edge in ARMED.
- autoRearm=1 with a trigger every 50 cycles → DONE lasts 1 cycle, then PRETRIG. Same-cycle abort+arm while in DONE → IDLE.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition capture path: state encoding and default widths.
// Readout and status logic import this so they decode the capture state identically.
package acq_pkg;

  localparam int unsigned AcqAddrW = 12;
  localparam int unsigned AcqDataW = 14;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPreTrig  = 3'd1,
    StArmed    = 3'd2,
    StPostTrig = 3'd3,
    StDone     = 3'd4
  } acqStateT;

  function automatic logic isCapturing(acqStateT s);
    return (s == StPreTrig) || (s == StArmed) || (s == StPostTrig);
  endfunction

endpackage

// File: rtl/acq_ring_addr.sv
// Wrapping write-address counter for the circular sample buffer.
// Advances once per cycle with en high and wraps naturally at 2^ADDR_W.
module acq_ring_addr
  import acq_pkg::*;
#(
  parameter int unsigned ADDR_W = AcqAddrW
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addrQ;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      addrQ <= '0;
    end else if (en) begin
      addrQ <= addrQ + ADDR_W'(1);
    end
  end

  assign addr = addrQ;

endmodule

// File: rtl/acq_capture_ctrl.sv
// Pre/post-trigger capture controller driving the write port of a circular sample RAM.
// Reports the ring address of the trigger sample for readout unrolling.
module acq_capture_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned ADDR_W = AcqAddrW,
  parameter int unsigned DATA_W = AcqDataW
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              autoRearm,
  input  logic [ADDR_W-1:0] preTrig,
  input  logic [ADDR_W-1:0] postTrig,
  input  logic              trigIn,
  input  logic [DATA_W-1:0] adc_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic              trigd
);

  localparam logic [ADDR_W+1:0] Depth = {2'b01, {ADDR_W{1'b0}}};

  acqStateT          stateQ, stateD;
  logic [ADDR_W-1:0] cntQ, cntD;
  logic [ADDR_W-1:0] preQ, preD;
  logic [ADDR_W-1:0] postQ, postD;
  logic [ADDR_W-1:0] trigAddrQ, trigAddrD;
  logic              trigPrevQ, trigdQ, wrEnQ, doneQ;
  logic [DATA_W-1:0] wrDataQ;
  logic [ADDR_W-1:0] ringAddr;
  logic [ADDR_W+1:0] winLen;
  logic [ADDR_W-1:0] postEffIn;
  logic [ADDR_W:0]   cntInc;
  logic              accept, armStart, autoStart;

  // Oversized window: keep every pre-trigger sample, shrink the post window to fit.
  assign winLen    = {2'b00, preTrig} + {2'b00, postTrig} + {{(ADDR_W+1){1'b0}}, 1'b1};
  assign postEffIn = (winLen > Depth) ? ~preTrig : postTrig;
  assign cntInc    = {1'b0, cntQ} + {{ADDR_W{1'b0}}, 1'b1};

  assign accept    = (stateQ == StArmed) && trigIn && !trigPrevQ && !abort;
  assign armStart  = arm && !abort && ((stateQ == StIdle) || (stateQ == StDone));
  assign autoStart = !arm && !abort && autoRearm && (stateQ == StDone);

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    preD      = preQ;
    postD     = postQ;
    trigAddrD = trigAddrQ;

    case (stateQ)
      StPreTrig: begin
        cntD = cntInc[ADDR_W-1:0];
        if (cntInc == {1'b0, preQ}) stateD = StArmed;
      end
      StArmed: begin
        if (accept) begin
          trigAddrD = ringAddr;
          cntD      = '0;
          stateD    = (postQ == '0) ? StDone : StPostTrig;
        end
      end
      StPostTrig: begin
        cntD = cntInc[ADDR_W-1:0];
        if (cntInc == {1'b0, postQ}) stateD = StDone;
      end
      StIdle, StDone: ;
      default: stateD = StIdle;
    endcase

    // Auto re-arm reuses the window latched by the last explicit arm.
    if (armStart) begin
      preD   = preTrig;
      postD  = postEffIn;
      cntD   = '0;
      stateD = (preTrig == '0) ? StArmed : StPreTrig;
    end else if (autoStart) begin
      cntD   = '0;
      stateD = (preQ == '0) ? StArmed : StPreTrig;
    end

    if (abort) stateD = StIdle;
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      preQ      <= '0;
      postQ     <= '0;
      trigAddrQ <= '0;
      trigPrevQ <= 1'b0;
      trigdQ    <= 1'b0;
      wrEnQ     <= 1'b0;
      doneQ     <= 1'b0;
      wrDataQ   <= '0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      preQ      <= preD;
      postQ     <= postD;
      trigAddrQ <= trigAddrD;
      trigPrevQ <= trigIn;
      trigdQ    <= accept;
      wrEnQ     <= isCapturing(stateD);
      doneQ     <= (stateD == StDone);
      wrDataQ   <= adc_data;
    end
  end

  acq_ring_addr #(
    .ADDR_W (ADDR_W)
  ) u_ring_addr (
    .clkIn (clkIn),
    .rst   (rst),
    .en    (wrEnQ),
    .addr  (ringAddr)
  );

  assign wr_en     = wrEnQ;
  assign wr_addr   = ringAddr;
  assign wr_data   = wrDataQ;
  assign trig_addr = trigAddrQ;
  assign busy      = wrEnQ;
  assign done      = doneQ;
  assign trigd     = trigdQ;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Bench for acq_capture_ctrl with a 16-entry ring: behavioural capture model checked every
// cycle, plus hand-computed addresses and write counts for the directed scenarios.
module tb_acq_capture_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 14;
  localparam int Depth = 1 << AW;

  logic          clkIn = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, autoRearm = 1'b0, trigIn = 1'b0;
  logic [AW-1:0] preTrig = '0, postTrig = '0;
  logic [DW-1:0] adc_data = 14'd5;
  logic          wr_en, busy, done, trigd;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW-1:0] wr_data;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clkIn = ~clkIn;

  acq_capture_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clkIn     (clkIn),
    .rst       (rst),
    .arm       (arm),
    .abort     (abort),
    .autoRearm (autoRearm),
    .preTrig   (preTrig),
    .postTrig  (postTrig),
    .trigIn    (trigIn),
    .adc_data  (adc_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .trig_addr (trig_addr),
    .busy      (busy),
    .done      (done),
    .trigd     (trigd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clkIn);
    adc_data = adc_data + 14'd1237;
  endtask

  // Behavioural model: mode 0 idle, 1 filling pre-trigger, 2 waiting, 3 post-trigger, 4 done.
  int            mMode = 0, mRem = 0, mPre = 0, mPost = 0, mAddr = 0, wrAddrNow = 0;
  logic          mPrev = 1'b0, rise = 1'b0;
  logic          eTrigd = 1'b0;
  logic [DW-1:0] eWrData = '0;
  int            eTrigAddr = 0;

  task automatic mStart(input int pre, input int post);
    mPre  = pre;
    mPost = (pre + post + 1 > Depth) ? Depth - 1 - pre : post;
    mRem  = pre;
    mMode = (pre == 0) ? 2 : 1;
  endtask

  initial forever begin
    @(posedge clkIn or posedge rst);
    if (rst) begin
      mMode = 0; mRem = 0; mAddr = 0; mPrev = 1'b0;
      eTrigd = 1'b0; eWrData = '0; eTrigAddr = 0;
    end else begin
      wrAddrNow = mAddr;
      rise      = trigIn && !mPrev;
      mPrev     = trigIn;
      eWrData   = adc_data;
      if (mMode >= 1 && mMode <= 3) mAddr = (mAddr + 1) % Depth;
      eTrigd = 1'b0;
      if (abort) begin
        mMode = 0;
      end else begin
        case (mMode)
          0: if (arm) mStart(int'(preTrig), int'(postTrig));
          1: begin mRem--; if (mRem == 0) mMode = 2; end
          2: if (rise) begin
            eTrigAddr = wrAddrNow;
            eTrigd    = 1'b1;
            mRem      = mPost;
            mMode     = (mPost == 0) ? 4 : 3;
          end
          3: begin mRem--; if (mRem == 0) mMode = 4; end
          4: begin
            if (arm) mStart(int'(preTrig), int'(postTrig));
            else if (autoRearm) mStart(mPre, mPost);
          end
          default: mMode = 0;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clkIn);
    check("cyc wr_en", 32'(wr_en), 32'(mMode >= 1 && mMode <= 3));
    check("cyc busy", 32'(busy), 32'(mMode >= 1 && mMode <= 3));
    check("cyc done", 32'(done), 32'(mMode == 4));
    check("cyc wr_addr", 32'(wr_addr), mAddr);
    check("cyc wr_data", 32'(wr_data), 32'(eWrData));
    check("cyc trig_addr", 32'(trig_addr), eTrigAddr);
    check("cyc trigd", 32'(trigd), 32'(eTrigd));
  end

  task automatic runToDone(input int budget, input string name, output int postWrites);
    bit seen;
    int n;
    seen = 0; n = 0; postWrites = 0;
    while (n < budget) begin
      tick();
      n++;
      if (trigd) seen = 1;
      if (seen && wr_en) postWrites++;
      if (seen && done) break;
    end
    check({name, " reached done"}, 32'(seen && done), 1);
  endtask

  task automatic checkAllZero(input string name);
    check({name, " wr_en"}, 32'(wr_en), 0);
    check({name, " wr_addr"}, 32'(wr_addr), 0);
    check({name, " wr_data"}, 32'(wr_data), 0);
    check({name, " trig_addr"}, 32'(trig_addr), 0);
    check({name, " busy"}, 32'(busy), 0);
    check({name, " done"}, 32'(done), 0);
    check({name, " trigd"}, 32'(trigd), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by t=%0t, %0d checks, %0d errors", $time, nChecks, nErrors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pw, nTrigd, nDone, run, maxRun;
    #1 rst = 1'b1;
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // A: pre 3, post 4, edge 10 cycles after arm
    preTrig = 4'd3; postTrig = 4'd4; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (9) tick();
    trigIn = 1'b1;
    runToDone(40, "A", pw);
    check("A post writes", pw, 4);
    check("A trig_addr", 32'(trig_addr), 9);
    check("A wr_addr at done", 32'(wr_addr), 14);
    tick();
    tick();
    check("A done held", 32'(done), 1);
    check("A wr_addr frozen", 32'(wr_addr), 14);

    // B: zero window, trigger already high at arm
    preTrig = 4'd0; postTrig = 4'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    nTrigd = int'(trigd);
    repeat (5) begin tick(); nTrigd += int'(trigd); end
    trigIn = 1'b0;
    tick();
    nTrigd += int'(trigd);
    check("B no accept while high", nTrigd, 0);
    check("B armed busy", 32'(busy), 1);
    trigIn = 1'b1;
    runToDone(10, "B", pw);
    check("B post writes", pw, 0);
    check("B trig_addr", 32'(trig_addr), 4);
    check("B wr_addr at done", 32'(wr_addr), 5);

    // C: 10 + 10 clamps to 5 post writes, wrapping 15 -> 0
    preTrig = 4'd10; postTrig = 4'd10; trigIn = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    nTrigd = int'(trigd);
    repeat (10) begin tick(); nTrigd += int'(trigd); end
    check("C no early accept", nTrigd, 0);
    trigIn = 1'b1;
    runToDone(20, "C", pw);
    check("C clamped post writes", pw, 5);
    check("C trig_addr", 32'(trig_addr), 15);
    check("C wr_addr at done", 32'(wr_addr), 5);

    // D: edge during pre-trigger fill is ignored
    preTrig = 4'd3; postTrig = 4'd2; trigIn = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    nTrigd = int'(trigd);
    tick();
    nTrigd += int'(trigd);
    trigIn = 1'b1;
    repeat (4) begin tick(); nTrigd += int'(trigd); end
    trigIn = 1'b0;
    repeat (2) begin tick(); nTrigd += int'(trigd); end
    check("D pretrig edge ignored", nTrigd, 0);
    trigIn = 1'b1;
    runToDone(10, "D", pw);
    check("D post writes", pw, 2);
    check("D trig_addr", 32'(trig_addr), 12);
    check("D wr_addr at done", 32'(wr_addr), 15);

    // E: auto re-arm with a trigger every 50 cycles
    preTrig = 4'd2; postTrig = 4'd1; autoRearm = 1'b1; trigIn = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    nTrigd = 0; nDone = 0; run = 0; maxRun = 0;
    for (int i = 1; i <= 150; i++) begin
      trigIn = (i % 50 == 10);
      tick();
      nTrigd += int'(trigd);
      nDone  += int'(done);
      run = done ? run + 1 : 0;
      if (run > maxRun) maxRun = run;
    end
    check("E trigger count", nTrigd, 3);
    check("E done cycles", nDone, 3);
    check("E done run length", maxRun, 1);
    autoRearm = 1'b0;
    trigIn = 1'b1;
    runToDone(10, "E2", pw);
    trigIn = 1'b0;
    check("E2 post writes", pw, 1);
    tick();
    check("E2 done held", 32'(done), 1);
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    check("abort+arm done", 32'(done), 0);
    check("abort+arm busy", 32'(busy), 0);
    check("abort+arm wr_en", 32'(wr_en), 0);
    tick();
    check("abort+arm stays idle", 32'(busy), 0);

    // F: asynchronous reset mid post-trigger
    preTrig = 4'd1; postTrig = 4'd8; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trigIn = 1'b1;
    tick();
    trigIn = 1'b0;
    check("F trigd", 32'(trigd), 1);
    tick();
    tick();
    check("F in post", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 checkAllZero("async rst");
    tick();
    rst = 1'b0;
    tick();
    check("F idle busy", 32'(busy), 0);
    check("F idle done", 32'(done), 0);
    check("F idle wr_en", 32'(wr_en), 0);
    check("F idle wr_addr", 32'(wr_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
